// File: rtl/_alu_pkg.sv
// Shared types and constants for the ALU result display path.
package _alu_pkg;

    localparam int ALU_WIDTH = 6;

    typedef logic [3:0] digit_t;

    localparam digit_t DIG_BLANK = 4'd10;
    localparam digit_t DIG_MINUS = 4'd11;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;

    localparam logic [2:0] LAST_STEP = 3'(ALU_WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

endpackage

// File: rtl/_seg7_encode.sv
// Digit code to active-low {g,f,e,d,c,b,a}; unknown codes are blank.
module _seg7_encode
    import _alu_pkg::*;
(
    input  digit_t     i_digit,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_digit)
            4'd0:      o_seg = 7'b1000000;
            4'd1:      o_seg = 7'b1111001;
            4'd2:      o_seg = 7'b0100100;
            4'd3:      o_seg = 7'b0110000;
            4'd4:      o_seg = 7'b0011001;
            4'd5:      o_seg = 7'b0010010;
            4'd6:      o_seg = 7'b0000010;
            4'd7:      o_seg = 7'b1111000;
            4'd8:      o_seg = 7'b0000000;
            4'd9:      o_seg = 7'b0010000;
            DIG_MINUS: o_seg = SEG_MINUS;
            default:   o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/_result_display_driver.sv
// ALU result to 4-digit seven-segment display: double-dabble BCD
// conversion with sign handling, then continuous digit scanning.
module _result_display_driver
    import _alu_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [ALU_WIDTH-1:0] value,
    input  logic                 signed_mode,
    output logic                 busy,
    output logic                 done,
    output logic [6:0]           seg,
    output logic [3:0]           an,
    output logic                 dp
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

    state_t               r_state;
    state_t               w_state_next;
    logic                 w_accept;
    logic                 w_last;

    logic [2:0]           r_step;
    logic [7:0]           r_bcd;
    logic [ALU_WIDTH-1:0] r_mag;
    logic                 r_neg;
    logic                 r_done;
    digit_t               r_dig [4];

    logic [CNT_W-1:0]     r_refresh;
    logic [1:0]           r_sel;
    logic [6:0]           r_seg;
    logic [3:0]           r_an;

    logic                 w_neg;
    logic [ALU_WIDTH-1:0] w_mag;
    logic [7:0]           w_adj;
    logic [13:0]          w_shift;
    digit_t               w_tens;
    digit_t               w_cur_digit;
    logic [6:0]           w_seg;

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            IDLE: begin
                if (load) begin
                    w_state_next = SHIFT;
                    w_accept     = 1'b1;
                end
            end
            SHIFT: begin
                if (r_step == LAST_STEP) begin
                    w_state_next = IDLE;
                    w_last       = 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_neg       = signed_mode & value[ALU_WIDTH-1];
        w_mag       = w_neg ? (~value + 6'd1) : value;
        w_adj[3:0]  = (r_bcd[3:0] >= 4'd5) ? r_bcd[3:0] + 4'd3 : r_bcd[3:0];
        w_adj[7:4]  = (r_bcd[7:4] >= 4'd5) ? r_bcd[7:4] + 4'd3 : r_bcd[7:4];
        w_shift     = {w_adj, r_mag} << 1;
        w_tens      = w_shift[13:10];
        w_cur_digit = r_dig[r_sel];
    end

    // Scratch only; the visible digits change solely on the final step.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_step   <= 3'd0;
            r_bcd    <= 8'd0;
            r_mag    <= '0;
            r_neg    <= 1'b0;
            r_done   <= 1'b0;
            r_dig[0] <= 4'd0;
            r_dig[1] <= DIG_BLANK;
            r_dig[2] <= DIG_BLANK;
            r_dig[3] <= DIG_BLANK;
        end else begin
            r_done <= w_last;
            if (w_accept) begin
                r_neg  <= w_neg;
                r_mag  <= w_mag;
                r_bcd  <= 8'd0;
                r_step <= 3'd0;
            end else if (r_state == SHIFT) begin
                r_bcd  <= w_shift[13:6];
                r_mag  <= w_shift[5:0];
                r_step <= r_step + 3'd1;
                if (w_last) begin
                    r_dig[0] <= w_shift[9:6];
                    r_dig[1] <= (w_tens == 4'd0) ? DIG_BLANK : w_tens;
                    r_dig[2] <= r_neg ? DIG_MINUS : DIG_BLANK;
                    r_dig[3] <= DIG_BLANK;
                end
            end
        end
    end

    _seg7_encode u_enc (
        .i_digit (w_cur_digit),
        .o_seg   (w_seg)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_refresh <= '0;
            r_sel     <= 2'd0;
            r_seg     <= SEG_ZERO;
            r_an      <= 4'b1110;
        end else begin
            r_seg <= w_seg;
            r_an  <= ~(4'b0001 << r_sel);
            if (r_refresh == CNT_MAX) begin
                r_refresh <= '0;
                r_sel     <= r_sel + 2'd1;
            end else begin
                r_refresh <= r_refresh + 1'b1;
            end
        end
    end

    assign busy = (r_state == SHIFT);
    assign done = r_done;
    assign seg  = r_seg;
    assign an   = r_an;
    assign dp   = 1'b1;

endmodule

// File: tb/tb__result_display_driver.sv
// Scoreboard bench: arithmetic decimal model feeds a queue of expected
// displays; a negedge monitor checks handshake, scan and segments.
module tb__result_display_driver;

    localparam int DIV = 4;

    typedef logic [3:0][6:0] disp_t;

    localparam logic [6:0] SB = 7'b1111111;
    localparam logic [6:0] SM = 7'b0111111;
    localparam logic [6:0] SEGTAB [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load = 1'b0;
    logic [5:0] value = 6'd0;
    logic       signed_mode = 1'b0;
    logic       busy, done, dp;
    logic [6:0] seg;
    logic [3:0] an;

    int npass = 0;
    int ntot  = 0;

    _result_display_driver #(.REFRESH_DIV(DIV)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load),
        .value       (value),
        .signed_mode (signed_mode),
        .busy        (busy),
        .done        (done),
        .seg         (seg),
        .an          (an),
        .dp          (dp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: actual %0h required %0h", name, act, exp);
    endtask

    function automatic disp_t model(input int v, input bit s);
        disp_t d;
        int    mag;
        bit    neg;
        neg = s && (v >= 32);
        mag = neg ? 64 - v : v;
        d[0] = SEGTAB[mag % 10];
        d[1] = (mag / 10 == 0) ? SB : SEGTAB[mag / 10];
        d[2] = neg ? SM : SB;
        d[3] = SB;
        return d;
    endfunction

    disp_t      q[$];
    int         mb = 0;
    bit         e_busy = 0;
    bit         e_done = 0;
    logic [3:0] e_an = 4'b1110;
    logic [1:0] e_slot = 0;
    logic [1:0] msel = 0;
    int         rc = 0;
    int         rst_gen = 0;
    bit         armed = 0;

    // Behavioural model of acceptance, latency and scan timing.
    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                mb = 0; e_done = 0; rc = 0; msel = 0;
                e_an = 4'b1110; e_slot = 0;
                rst_gen++; armed = 1;
            end else begin
                e_an = ~(4'b0001 << msel);
                e_slot = msel;
                if (rc == DIV - 1) begin rc = 0; msel = msel + 2'd1; end
                else rc++;
                e_done = (mb == 1);
                if (mb > 0) mb--;
                else if (load) begin
                    mb = 6;
                    q.push_back(model(int'(value), signed_mode));
                end
            end
            e_busy = (mb > 0);
        end
    end

    disp_t cur;
    disp_t pending;
    bit    apply = 0;
    int    seen = 0;

    initial begin
        cur = {SB, SB, SB, SEGTAB[0]};
        forever begin
            @(negedge clk);
            if (armed) begin
                if (rst_gen != seen) begin
                    seen = rst_gen;
                    q.delete();
                    cur = {SB, SB, SB, SEGTAB[0]};
                    apply = 0;
                end
                if (apply) begin cur = pending; apply = 0; end
                chk("busy", 32'(busy), 32'(e_busy));
                chk("done", 32'(done), 32'(e_done));
                chk("dp", 32'(dp), 32'd1);
                chk("an", 32'(an), 32'(e_an));
                chk("seg", 32'(seg), 32'(cur[e_slot]));
                if (done === 1'b1) begin
                    if (q.size() == 0) begin
                        chk("done_without_load", 32'd1, 32'd0);
                    end else begin
                        pending = q.pop_front();
                        apply = 1;
                    end
                end
            end
        end
    end

    task automatic step(input bit l, input logic [5:0] v, input bit s);
        load = l; value = v; signed_mode = s;
        @(posedge clk); #2;
        load = 1'b0;
        value = 6'($urandom);
        signed_mode = 1'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 6'($urandom), 1'($urandom));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        chk("reset_an", 32'(an), 32'h e);
        chk("reset_seg", 32'(seg), 32'h40);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        idle(4);

        step(1, 6'd63, 0);       idle(20);
        step(1, 6'b100000, 1);   idle(20);
        step(1, 6'b100000, 0);   idle(20);
        step(1, 6'd5, 0);        idle(20);
        step(1, 6'd0, 1);        idle(20);
        step(1, 6'd42, 0);       idle(2);
        step(1, 6'd1, 0);        idle(20);
        step(1, 6'd7, 0);        idle(6);
        step(1, 6'b110011, 1);   idle(20);

        step(1, 6'd50, 0);       idle(2);
        rst_n = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b1;
        idle(20);
        step(1, 6'd27, 0);       idle(20);

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                rst_n = 1'b0;
                @(posedge clk); #2;
                rst_n = 1'b1;
            end else begin
                step($urandom_range(0, 2) == 0, 6'($urandom), 1'($urandom));
            end
        end
        idle(20);

        @(negedge clk); #1;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
